hoeraa_reg: RTL and testbench

- Registered N-bit approximate adder using the HOERAA scheme (hardware-optimized, error-reduced approximate adder).
- The upper N-K bits form an exact ripple/behavioural adder.
- The lower K bits form a cheap inexact part that also generates the carry into the exact part.
- Used as a low-power datapath adder where bounded error in the low-order bits is acceptable. One output register stage.

---
 rtl/hoeraa_reg.sv | 59 +++++
 tb/tb_hoeraa_reg.sv | 107 ++++++++++
 2 files changed

// File: rtl/hoeraa_reg.sv
// Registered HOERAA approximate adder: cheap inexact low part plus exact high part.
// The low part also supplies the carry into the high part. All outputs come from flops.
module hoeraa_reg #(
    parameter int N = 16,
    parameter int K = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic         out_valid,
    output logic [N-1:0] S,
    output logic         Co
);

    generate
        if (N < 4 || K < 2 || K > N - 1) begin : gIllegalParams
            $error("hoeraa_reg: illegal parameters N=%0d K=%0d", N, K);
        end
    endgenerate

    logic [N-1:0]   sum_d, sum_q;
    logic           co_d, co_q;
    logic           valid_q;
    logic           cin;
    logic [N-K:0]   upper;

    // The constant-ones low bits make zero operands produce 2^(K-1)-1 on purpose.
    always_comb begin
        cin   = X[K-1] & Y[K-1];
        upper = {1'b0, X[N-1:K]} + {1'b0, Y[N-1:K]} + {{(N-K){1'b0}}, cin};
        sum_d = '0;
        sum_d[K-2:0] = '1;
        sum_d[K-1]   = X[K-1] | Y[K-1] | (X[K-2] & Y[K-2]);
        sum_d[N-1:K] = upper[N-K-1:0];
        co_d  = upper[N-K];
    end

    // Idle cycles leave the last result in place and only clear out_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= '0;
            co_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q <= sum_d;
                co_q  <= co_d;
            end
        end
    end

    assign S         = sum_q;
    assign Co        = co_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_hoeraa_reg.sv
// Directed bench for hoeraa_reg at N=16, K=9 with hand-computed expected results.
module tb_hoeraa_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] X;
    logic [15:0] Y;
    logic        out_valid;
    logic [15:0] S;
    logic        Co;

    int compared;
    int mismatched;

    hoeraa_reg #(.N(16), .K(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .S         (S),
        .Co        (Co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of stimulus away from the edge, then sample just after the edge.
    task automatic applyStimulus(input logic rst, input logic vld, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        rst_n    = rst;
        in_valid = vld;
        X        = a;
        Y        = b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResult(input string tag, input logic [15:0] expS, input logic expCo, input logic expValid);
        checkOutput({tag, ".S"}, {16'h0, S}, {16'h0, expS});
        checkOutput({tag, ".Co"}, {31'h0, Co}, {31'h0, expCo});
        checkOutput({tag, ".valid"}, {31'h0, out_valid}, {31'h0, expValid});
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        X          = '0;
        Y          = '0;

        applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
        applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
        checkResult("reset", 16'h0000, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 16'h0000, 16'h0000);
        checkResult("zero", 16'h00FF, 1'b0, 1'b1);

        applyStimulus(1'b1, 1'b1, 16'h0001, 16'h0001);
        checkResult("one_one", 16'h00FF, 1'b0, 1'b1);

        applyStimulus(1'b1, 1'b1, 16'h00FF, 16'h00FF);
        checkResult("low_and", 16'h01FF, 1'b0, 1'b1);

        applyStimulus(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        checkResult("all_ones", 16'hFFFF, 1'b1, 1'b1);

        applyStimulus(1'b1, 1'b1, 16'h0100, 16'h0100);
        checkResult("cin_only", 16'h03FF, 1'b0, 1'b1);

        applyStimulus(1'b1, 1'b1, 16'h0100, 16'h0000);
        checkResult("x_bit8", 16'h01FF, 1'b0, 1'b1);

        applyStimulus(1'b1, 1'b1, 16'h8000, 16'h8000);
        checkResult("upper_ovf", 16'h00FF, 1'b1, 1'b1);

        applyStimulus(1'b1, 1'b1, 16'h5555, 16'hAAAA);
        checkResult("b2b_first", 16'hFFFF, 1'b0, 1'b1);

        applyStimulus(1'b1, 1'b1, 16'h8001, 16'h0101);
        checkResult("b2b_second", 16'h81FF, 1'b0, 1'b1);

        applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
        checkResult("hold", 16'h81FF, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b0, 16'h1234, 16'h4321);
        checkResult("hold2", 16'h81FF, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
        checkResult("reset_again", 16'h0000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
